// File: rtl/mem_twoport_pkg.sv
// rtl/mem_twoport_pkg.sv - shared types and helpers for the byte-enable two-port RAM
package mem_twoport_pkg;

  typedef enum logic {INIT, RUN} mem_state_t;

  localparam int DEF_BYTE_W = 8;

  function automatic int lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/mem_twoport_init.sv
// rtl/mem_twoport_init.sv - post-reset clear sequencer: walks every address once, then releases the ports
module mem_twoport_init
  import mem_twoport_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  mem_state_t    state, state_nxt;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    init_we   = 1'b0;
    init_busy = 1'b0;
    case (state)
      INIT: begin
        init_we   = 1'b1;
        init_busy = 1'b1;
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = INIT;
    endcase
  end

  assign init_addr = cnt;

endmodule

// File: rtl/mem_twoport_be.sv
// rtl/mem_twoport_be.sv - simple-dual-port RAM with byte enables, write-first forwarding and self-clear
// Optional: MEM_TWOPORT_BE_OUTREG_EN adds an output register stage (read latency 2).
module mem_twoport_be
  import mem_twoport_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               BYTE_W   = DEF_BYTE_W,
  parameter int               DEPTH    = 512,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              NL       = lanes(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [NL-1:0]     be,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              init_busy
);

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("mem_twoport_be: DATA_W must be a multiple of BYTE_W");
  end

  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic              ra_ok, wa_ok, rd_acc;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NL-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] q1;
  logic              v1;

  mem_twoport_init #(.DEPTH(DEPTH), .AW(AW)) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_busy (init_busy)
  );

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  assign ra_ok  = {1'b0, ra} < DEPTH_X;
  assign wa_ok  = {1'b0, wa} < DEPTH_X;
  assign rd_acc = re & ~init_busy;

  assign wr_en   = ~rst & (init_we | (we & wa_ok & ~init_busy));
  assign wr_addr = init_busy ? init_addr : wa;
  assign wr_be   = init_busy ? {NL{1'b1}} : be;
  assign wr_data = init_busy ? INIT_VAL : d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Write-first: a same-address write patches its enabled lanes into the read word.
  always_comb begin
    rd_word = '0;
    if (ra_ok) rd_word = mem[ra];
    if (we && wa_ok && ra == wa) begin
      for (int i = 0; i < NL; i++) begin
        if (be[i]) rd_word[i*BYTE_W +: BYTE_W] = d[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) q1 <= rd_word;
    end
  end

`ifdef MEM_TWOPORT_BE_OUTREG_EN
  logic [DATA_W-1:0] q2;
  logic              v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      q2 <= '0;
      v2 <= 1'b0;
    end else begin
      q2 <= q1;
      v2 <= v1;
    end
  end

  assign q       = q2;
  assign q_valid = v2;
`else
  assign q       = q1;
  assign q_valid = v1;
`endif

endmodule

// File: doc/mem_twoport_be.md
Name: mem_twoport_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. Successor to the fixed 20x512 two-port memory.
- Adds per-byte write enables, a read enable with output valid, write-first read-during-write forwarding, and a self-clearing initialisation sequence after reset.
- Used as line/sample buffer storage between datapath stages.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per write-enable lane.
- DEPTH, 512, number of words; need not be a power of two.
- INIT_VAL, 0, value written to every word during the init sequence (DATA_W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ra  in  AW=$clog2(DEPTH)  read address.
- re  in  1  read enable.
- wa  in  AW  write address.
- we  in  1  write enable.
- be  in  DATA_W/BYTE_W  byte-lane enables, qualified by we.
- d  in  DATA_W  write data.
- q  out  DATA_W  read data, registered.
- q_valid  out  1  q holds data from a read accepted the previous cycle.
- init_busy  out  1  high while the clear sequence runs; ports ignored.

Behaviour:
- Reset (rst=1 at posedge): q=0, q_valid=0, init_busy=1, FSM->INIT, init counter=0. Reset asserted mid-operation (in any state, including mid-INIT) restarts INIT from address 0.
- INIT: each cycle writes INIT_VAL to mem[counter], counter++. At counter==DEPTH-1 the write occurs, FSM->RUN next cycle. Takes exactly DEPTH cycles; init_busy falls on the cycle RUN is entered. we/re are ignored; q_valid stays 0.
- RUN write: when we=1, for each lane i with be[i]=1, mem[wa][i*BYTE_W +: BYTE_W] <= d lane i. Lanes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
- RUN read: when re=1, q <= mem[ra] one cycle later and q_valid=1 for that cycle. When re=0, q holds its previous value and q_valid=0.
- Read-during-write (re&we, ra==wa): write-first. q returns the old word with the enabled lanes replaced by d; lanes with be=0 are old data.
- Out-of-range address (>=DEPTH, non-power-of-two DEPTH): write is dropped. Read returns 0 with q_valid=1.
- Simultaneous read/write at different addresses: independent, no stall.

Optional Feature:
- MEM_TWOPORT_BE_OUTREG_EN defined: adds an output pipeline register after q. Read latency becomes 2. q_valid is delayed identically. Forwarding is decided at the read cycle, so the value equals the write-first result at issue. Reset clears both stages.
- Undefined: read latency 1, as above.

Decomposition:
- Package mem_twoport_pkg:
  - typedef enum logic {INIT, RUN} mem_state_t
  - localparam DEF_BYTE_W=8
  - function lanes(DATA_W, BYTE_W)
- Sub-module mem_twoport_init: FSM plus DEPTH counter, outputs init_we, init_addr, init_busy. Main module muxes init vs user write port.
- Elaboration-time check: DATA_W % BYTE_W == 0, else $error.

Test Plan:
- Init: assert rst 1 cycle, DEPTH=512 -> init_busy high exactly 512 cycles. Then reads of addr 0, 255, 511 return 0x00000000 with q_valid=1.
- Byte write: write 0xAABBCCDD be=4'b1111 to addr 5, then 0x11223344 be=4'b0101 to addr 5; read addr 5 -> 0xAA22CC44.
- Forwarding: addr 7 holds 0x01020304. Same cycle we=1 wa=7 d=0xFFFFFFFF be=4'b1000, re=1 ra=7 -> next cycle q=0xFF020304.
- Hold/valid: read addr 5, then re=0 for 3 cycles -> q stays 0xAA22CC44, q_valid 1 then 0,0,0.
- Reset mid-RUN and mid-INIT: rst at INIT cycle 100 -> init restarts, busy 512 more cycles. Previously written addr 5 reads 0.
- DEPTH=300: write 0x12345678 to addr 310 -> dropped. Read 310 -> 0, q_valid=1. Addr 299 writes and reads back normally.
- With MEM_TWOPORT_BE_OUTREG_EN: repeat the forwarding test -> 0xFF020304 appears 2 cycles after issue.
